motor_pwm_drive: RTL and testbench

//  Consumer of the avoidance/tracking decoder's motor command word (zuo1/zuo2/en1, you1/you2/en2,
//  ENE). Converts per-side FWD/REV/STOP commands into H-bridge (L298N-style) IN1/IN2/ENA drive.

---
 rtl/motor_pwm_drive.sv | 249 ++++++++++++++++++++++++
 tb/tb_motor_pwm_drive.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_drive.sv
// motor_pwm_drive
//   Turns the decision logic's per-side FWD/REV/STOP command bits into
//   L298N-style H-bridge drive (IN1/IN2/ENA). Each side soft-starts its PWM
//   duty and holds the bridge fully off for a fixed dead time on every stop
//   or direction reversal.
//
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   ENE            global disable, forces STOP on both sides
//   zuo1/zuo2/en1  left forward / reverse / enable requests
//   you1/you2/en2  right forward / reverse / enable requests
//   l_in1/l_in2    left bridge forward / reverse legs
//   l_ena          left bridge PWM enable
//   r_in1/r_in2    right bridge forward / reverse legs
//   r_ena          right bridge PWM enable
//   l_busy/r_busy  side is holding its dead time

// motor_side_fsm
//   One bridge side: run/dead-time sequencing, duty ramp and PWM compare.
//
//   clk, rst_n     clock and asynchronous active-low reset
//   go_fwd/go_rev  decoded, synchronized command (never both 1)
//   pwm_cnt        shared free-running PWM counter
//   pwm_wrap       pwm_cnt is on its last count of the period
//   in1/in2/ena    bridge drive
//   busy           side is in DEAD
//
//   state | meaning
//   IDLE  | bridge off, waiting for a FWD/REV command
//   RUN   | one leg on in the latched direction, ENA is the PWM
//   DEAD  | bridge off for DEAD_TIME cycles, commands ignored
module motor_side_fsm #(
  parameter int DUTY_MAX  = 255,
  parameter int RAMP_DIV  = 1024,
  parameter int RAMP_STEP = 4,
  parameter int DEAD_TIME = 5000,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go_fwd,
  input  logic         go_rev,
  input  logic [W-1:0] pwm_cnt,
  input  logic         pwm_wrap,
  output logic         in1,
  output logic         in2,
  output logic         ena,
  output logic         busy
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  localparam logic [RW-1:0] RAMP_TC   = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_TIME - 1);
  localparam logic [W-1:0]  DUTY_FULL = W'(DUTY_MAX);
  localparam logic [W:0]    STEP_X    = (W+1)'(RAMP_STEP);
  localparam logic [W:0]    FULL_X    = (W+1)'(DUTY_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t        state, state_nxt;
  logic          start_run, leave_run;
  logic          dir_fwd;
  logic [RW-1:0] ramp_cnt;
  logic [TW-1:0] dead_cnt;
  logic [W-1:0]  duty, duty_act;
  logic [W:0]    duty_sum;

  // One bit wider than duty so the saturation compare sees the carry.
  assign duty_sum = {1'b0, duty} + STEP_X;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    leave_run = 1'b0;
    in1       = 1'b0;
    in2       = 1'b0;
    ena       = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (go_fwd || go_rev) begin
          state_nxt = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        in1 = dir_fwd;
        in2 = ~dir_fwd;
        ena = (pwm_cnt < duty_act);
        // Anything other than the latched direction (stop or reversal)
        // must pass through the dead time.
        if (!(dir_fwd ? go_fwd : go_rev)) begin
          state_nxt = DEAD;
          leave_run = 1'b1;
        end
      end
      DEAD: begin
        busy = 1'b1;
        if (dead_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_fwd  <= 1'b0;
      ramp_cnt <= '0;
      duty     <= '0;
    end else if (start_run) begin
      dir_fwd  <= go_fwd;
      ramp_cnt <= '0;
      duty     <= '0;
    end else if (leave_run) begin
      ramp_cnt <= '0;
      duty     <= '0;
    end else if (state == RUN) begin
      if (ramp_cnt == RAMP_TC) begin
        ramp_cnt <= '0;
        duty     <= (duty_sum > FULL_X) ? DUTY_FULL : duty_sum[W-1:0];
      end else begin
        ramp_cnt <= ramp_cnt + RW'(1);
      end
    end
  end

  // Dead timer: loaded on the leaving edge, DEAD ends on its terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                dead_cnt <= '0;
    else if (leave_run)                        dead_cnt <= DEAD_LOAD;
    else if (state == DEAD && dead_cnt != '0)  dead_cnt <= dead_cnt - TW'(1);
  end

  // The compare value only moves at the period boundary so a ramp tick
  // never chops a PWM pulse; leaving RUN clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         duty_act <= '0;
    else if (leave_run) duty_act <= '0;
    else if (pwm_wrap)  duty_act <= duty;
  end

endmodule

module motor_pwm_drive #(
  parameter int DUTY_MAX  = 255,
  parameter int RAMP_DIV  = 1024,
  parameter int RAMP_STEP = 4,
  parameter int DEAD_TIME = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ENE,
  input  logic zuo1,
  input  logic zuo2,
  input  logic en1,
  input  logic you1,
  input  logic you2,
  input  logic en2,
  output logic l_in1,
  output logic l_in2,
  output logic l_ena,
  output logic r_in1,
  output logic r_in2,
  output logic r_ena,
  output logic l_busy,
  output logic r_busy
);

  localparam int W = $clog2(DUTY_MAX + 1);
  localparam logic [W-1:0] PWM_LAST = W'(DUTY_MAX - 1);

  logic [6:0]   sync1, sync2;
  logic [W-1:0] pwm_cnt;
  logic         pwm_wrap;
  logic         ene_s, zuo1_s, zuo2_s, en1_s, you1_s, you2_s, en2_s;
  logic         l_fwd, l_rev, r_fwd, r_rev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ENE, zuo1, zuo2, en1, you1, you2, en2};
      sync2 <= sync1;
    end
  end

  assign {ene_s, zuo1_s, zuo2_s, en1_s, you1_s, you2_s, en2_s} = sync2;

  // fwd==rev decodes as STOP, so go_fwd and go_rev are never both set.
  assign l_fwd = ~ene_s & en1_s &  zuo1_s & ~zuo2_s;
  assign l_rev = ~ene_s & en1_s & ~zuo1_s &  zuo2_s;
  assign r_fwd = ~ene_s & en2_s &  you1_s & ~you2_s;
  assign r_rev = ~ene_s & en2_s & ~you1_s &  you2_s;

  assign pwm_wrap = (pwm_cnt == PWM_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pwm_cnt <= '0;
    else if (pwm_wrap) pwm_cnt <= '0;
    else               pwm_cnt <= pwm_cnt + W'(1);
  end

  motor_side_fsm #(
    .DUTY_MAX (DUTY_MAX),
    .RAMP_DIV (RAMP_DIV),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_TIME(DEAD_TIME),
    .W        (W)
  ) u_left (
    .clk     (clk),
    .rst_n   (rst_n),
    .go_fwd  (l_fwd),
    .go_rev  (l_rev),
    .pwm_cnt (pwm_cnt),
    .pwm_wrap(pwm_wrap),
    .in1     (l_in1),
    .in2     (l_in2),
    .ena     (l_ena),
    .busy    (l_busy)
  );

  motor_side_fsm #(
    .DUTY_MAX (DUTY_MAX),
    .RAMP_DIV (RAMP_DIV),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_TIME(DEAD_TIME),
    .W        (W)
  ) u_right (
    .clk     (clk),
    .rst_n   (rst_n),
    .go_fwd  (r_fwd),
    .go_rev  (r_rev),
    .pwm_cnt (pwm_cnt),
    .pwm_wrap(pwm_wrap),
    .in1     (r_in1),
    .in2     (r_in2),
    .ena     (r_ena),
    .busy    (r_busy)
  );

endmodule

// File: tb/tb_motor_pwm_drive.sv
// tb_motor_pwm_drive
//   Directed sequences followed by randomized commands for motor_pwm_drive.
//   The reference keeps, per side, the current mode with the time RUN
//   started and the time DEAD ends; duty and the PWM pattern are computed
//   from elapsed time with plain arithmetic.
module tb_motor_pwm_drive;

  localparam int DMAX  = 8;
  localparam int RDIV  = 4;
  localparam int RSTEP = 2;
  localparam int DT    = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ene = 1'b0, zuo1 = 1'b0, zuo2 = 1'b0, en1 = 1'b0;
  logic you1 = 1'b0, you2 = 1'b0, en2 = 1'b0;
  logic l_in1, l_in2, l_ena, r_in1, r_in2, r_ena, l_busy, r_busy;

  always #5 clk = ~clk;

  motor_pwm_drive #(
    .DUTY_MAX (DMAX),
    .RAMP_DIV (RDIV),
    .RAMP_STEP(RSTEP),
    .DEAD_TIME(DT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ENE   (ene),
    .zuo1  (zuo1),
    .zuo2  (zuo2),
    .en1   (en1),
    .you1  (you1),
    .you2  (you2),
    .en2   (en2),
    .l_in1 (l_in1),
    .l_in2 (l_in2),
    .l_ena (l_ena),
    .r_in1 (r_in1),
    .r_in2 (r_in2),
    .r_ena (r_ena),
    .l_busy(l_busy),
    .r_busy(r_busy)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Cycle k is the interval after the k-th rising edge since reset release.
  int k;
  int hist[2][16];      // decoded command per cycle: 0 stop, 1 fwd, 2 rev
  int mode[2];          // 0 idle, 1 run, 2 dead
  int dir[2];
  int run_start[2];
  int dead_end[2];

  function automatic int decode(logic e, logic en, logic f, logic r);
    if (e || !en || (f == r)) return 0;
    return f ? 1 : 2;
  endfunction

  function automatic int duty_at(int s, int c);
    int v;
    if (c < run_start[s]) return 0;
    v = RSTEP * ((c - run_start[s]) / RDIV);
    return (v > DMAX) ? DMAX : v;
  endfunction

  // {in1, in2, ena, busy} the side should show in cycle k.
  function automatic logic [3:0] exp_side(int s);
    logic run;
    int   dact;
    run  = (mode[s] == 1);
    dact = duty_at(s, k - (k % DMAX) - 1);
    return {run && dir[s] == 1, run && dir[s] == 2,
            run && ((k % DMAX) < dact), mode[s] == 2};
  endfunction

  function automatic logic [7:0] outs();
    return {l_in1, l_in2, l_ena, l_busy, r_in1, r_in2, r_ena, r_busy};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s k=%0d observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int s = 0; s < 2; s++) begin
      mode[s] = 0; dir[s] = 0; run_start[s] = 0; dead_end[s] = 0;
      for (int i = 0; i < 16; i++) hist[s][i] = 0;
    end
  endtask

  // Called at posedge+1: records this cycle's command, advances one edge,
  // updates the reference, then checks every output.
  task automatic tick();
    int c;
    hist[0][k % 16] = decode(ene, en1, zuo1, zuo2);
    hist[1][k % 16] = decode(ene, en2, you1, you2);
    @(posedge clk);
    k++;
    for (int s = 0; s < 2; s++) begin
      c = (k >= 3) ? hist[s][(k - 3) % 16] : 0;
      case (mode[s])
        0: if (c != 0) begin mode[s] = 1; dir[s] = c; run_start[s] = k; end
        1: if (c != dir[s]) begin mode[s] = 2; dead_end[s] = k + DT; end
        default: if (k == dead_end[s]) mode[s] = 0;
      endcase
    end
    #1;
    check("outs", outs(), {exp_side(0), exp_side(1)});
    check("overlap", {6'b0, l_in1 & l_in2, r_in1 & r_in2}, 8'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Entered at posedge+1 (or time 0); returns at posedge+1 right after release.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async", outs(), 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", outs(), 8'h00);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int hold;

    // Reset with left FWD already requested; ramp to full duty.
    en1 = 1'b1; zuo1 = 1'b1;
    do_reset();
    ticks(2);
    check("fwd_not_yet", {7'b0, l_in1}, 8'h00);
    tick();
    check("fwd_3rd_edge", {6'b0, l_in1, l_ena}, 8'h02);
    ticks(40);
    check("full_duty_ena", {7'b0, l_ena}, 8'h01);

    // Right side REV alongside.
    en2 = 1'b1; you2 = 1'b1;
    ticks(40);

    // Left reversal through dead time.
    zuo1 = 1'b0; zuo2 = 1'b1;
    ticks(3);
    check("rev_dead", {6'b0, l_in1, l_busy}, 8'h01);
    ticks(5);
    check("rev_idle", {5'b0, l_in1, l_in2, l_busy}, 8'h00);
    tick();
    check("rev_run", {6'b0, l_in2, l_busy}, 8'h02);
    ticks(30);

    // One-cycle global disable at full duty on both sides.
    ene = 1'b1; tick(); ene = 1'b0;
    ticks(40);

    // Global disable toggling inside the dead window.
    ene = 1'b1; tick(); ene = 1'b0;
    ticks(4);
    ene = 1'b1; tick(); ene = 1'b0; tick();
    ene = 1'b1; tick(); ene = 1'b0;
    ticks(30);

    // Both legs requested -> stop on the left only.
    zuo1 = 1'b1; zuo2 = 1'b1;
    ticks(20);
    zuo1 = 1'b0;
    ticks(30);

    // Restart so ramp ticks land mid-period (RUN starts at pwm_cnt 7).
    en1 = 1'b0;
    ticks(20);
    for (int i = 0; i < DMAX && (k % DMAX) != 4; i++) tick();
    en1 = 1'b1; zuo1 = 1'b1; zuo2 = 1'b0;
    ticks(40);

    // Reset in the second cycle of a dead window, then restart with no dead time.
    en1 = 1'b0;
    ticks(4);
    check("dead_before_rst", {7'b0, l_busy}, 8'h01);
    en1 = 1'b1; zuo1 = 1'b1;
    do_reset();
    ticks(3);
    check("fwd_after_rst", {6'b0, l_in1, l_busy}, 8'h02);
    ticks(10);

    // Randomized command sequences with occasional resets.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset();
      end else begin
        ene  = ($urandom_range(0, 9) == 0);
        en1  = ($urandom_range(0, 5) != 0);
        zuo1 = 1'($urandom_range(0, 1));
        zuo2 = 1'($urandom_range(0, 1));
        en2  = ($urandom_range(0, 5) != 0);
        you1 = 1'($urandom_range(0, 1));
        you2 = 1'($urandom_range(0, 1));
      end
      hold = int'($urandom_range(1, 30));
      ticks(hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
